// File: rtl/matrix_mac_sequencer.sv
// Math box MAC sequencer: ACC += (A - B) * C with a serial radix-2 multiplier.
// MACFLAG holds off matrix instruction fetch for the 18 busy cycles.
module matrix_mac_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned RES_LSB = 15
) (
  input  logic              clk_12,
  input  logic              reset,
  input  logic              LDA,
  input  logic              LDB,
  input  logic              LDC,
  input  logic              CLEARACC,
  input  logic              LAC,
  input  logic [DATA_W-1:0] MDB_RAM,
  output logic              MACFLAG,
  output logic [DATA_W-1:0] MDB_OUT,
  output logic [ACC_W-1:0]  ACC,
  output logic              PROTO_ERR
);

  localparam int unsigned D_W   = DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SUB, MUL, ACCUM} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [ACC_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  mdb_q, mdb_d;
  logic               perr_q, perr_d;
  logic               macflag_q, macflag_d;
  logic signed [D_W-1:0] diff_c;
  logic               last_bit_c;

  assign diff_c     = D_W'($signed(a_q)) - D_W'($signed(b_q));
  assign last_bit_c = (cnt_q == CNT_W'(DATA_W - 1));

  // Only the low ACC_W product bits reach ACC, so the partial sum runs modulo 2^ACC_W.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mdb_d     = mdb_q;
    perr_d    = perr_q;

    if (LAC)      mdb_d = acc_q[RES_LSB +: DATA_W];
    if (CLEARACC) acc_d = '0;
    if ((state_q != IDLE) && (LDA || LDB || LDC)) perr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (LDA) a_d = MDB_RAM;
        if (LDB) b_d = MDB_RAM;
        if (LDC) begin
          c_d     = MDB_RAM;
          state_d = SUB;
        end
      end
      SUB: begin
        mcand_d = ACC_W'(diff_c);
        prod_d  = '0;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        // C's MSB carries negative weight in two's complement
        if (c_q[cnt_q]) prod_d = last_bit_c ? (prod_q - mcand_q) : (prod_q + mcand_q);
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit_c) state_d = ACCUM;
      end
      ACCUM: begin
        acc_d   = acc_d + prod_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    macflag_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_12 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mdb_q     <= '0;
      perr_q    <= 1'b0;
      macflag_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mdb_q     <= mdb_d;
      perr_q    <= perr_d;
      macflag_q <= macflag_d;
    end
  end

  assign MACFLAG   = macflag_q;
  assign MDB_OUT   = mdb_q;
  assign ACC       = acc_q;
  assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Scoreboard bench for matrix_mac_sequencer: directed cases plus randomized MAC traffic
// against a transaction-level model of the accumulator.
module tb_matrix_mac_sequencer;

  logic        clk_12 = 1'b0;
  logic        reset;
  logic        LDA, LDB, LDC, CLEARACC, LAC;
  logic [15:0] MDB_RAM;
  logic        MACFLAG;
  logic [15:0] MDB_OUT;
  logic [31:0] ACC;
  logic        PROTO_ERR;

  matrix_mac_sequencer dut (
    .clk_12(clk_12), .reset(reset), .LDA(LDA), .LDB(LDB), .LDC(LDC),
    .CLEARACC(CLEARACC), .LAC(LAC), .MDB_RAM(MDB_RAM), .MACFLAG(MACFLAG),
    .MDB_OUT(MDB_OUT), .ACC(ACC), .PROTO_ERR(PROTO_ERR)
  );

  always #5 clk_12 = ~clk_12;

  int checks = 0;
  int passed = 0;

  // Reference model state; done_e is the edge number at which the pending product lands.
  logic [15:0] a_m = '0, b_m = '0, c_m = '0;
  logic [31:0] acc_m = '0, prod_m = '0;
  logic        perr_m = 1'b0;
  int          cyc = 0;
  int          done_e = -1;
  logic [31:0] acc_q[$];
  logic [15:0] mdb_q[$];

  logic lac_seen = 1'b0;
  logic prev_flag = 1'b1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got nothing expected an entry (t=%0t)", name, $time);
  endtask

  task automatic model_edge(input logic lda, ldb, ldc, clr, lac, input logic [15:0] d);
    logic busy;
    longint diff, p;
    busy = (done_e >= cyc);
    if (lac) mdb_q.push_back(acc_m[30:15]);
    if (clr) acc_m = '0;
    if (done_e == cyc) begin
      acc_m = acc_m + prod_m;
      acc_q.push_back(acc_m);
    end
    if (busy) begin
      if (lda || ldb || ldc) perr_m = 1'b1;
    end else begin
      if (lda) a_m = d;
      if (ldb) b_m = d;
      if (ldc) begin
        c_m    = d;
        diff   = longint'($signed(a_m)) - longint'($signed(b_m));
        p      = diff * longint'($signed(c_m));
        prod_m = p[31:0];
        done_e = cyc + 18;
      end
    end
  endtask

  task automatic step(input logic lda, ldb, ldc, clr, lac, input logic [15:0] d);
    LDA = lda; LDB = ldb; LDC = ldc; CLEARACC = clr; LAC = lac; MDB_RAM = d;
    @(posedge clk_12);
    cyc++;
    model_edge(lda, ldb, ldc, clr, lac, d);
    #1;
    LDA = 1'b0; LDB = 1'b0; LDC = 1'b0; CLEARACC = 1'b0; LAC = 1'b0; MDB_RAM = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, b);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    a_m = '0; b_m = '0; c_m = '0; acc_m = '0; prod_m = '0; perr_m = 1'b0;
    done_e = -1;
    acc_q.delete();
    mdb_q.delete();
    #1;
    check32("reset_macflag", 32'(MACFLAG), 32'd1);
    check32("reset_acc", ACC, 32'd0);
    check32("reset_mdb_out", 32'(MDB_OUT), 32'd0);
    check32("reset_proto_err", 32'(PROTO_ERR), 32'd0);
    @(negedge clk_12);
    @(posedge clk_12);
    @(negedge clk_12);
    reset = 1'b0;
  endtask

  always @(posedge clk_12) lac_seen <= LAC && !reset;

  // Monitor: cycle-level comparison plus scoreboard pops on LAC results and MAC completions.
  always @(negedge clk_12) begin
    if (reset) begin
      prev_flag = 1'b1;
    end else begin
      check32("macflag", 32'(MACFLAG), (done_e > cyc) ? 32'd0 : 32'd1);
      check32("acc", ACC, acc_m);
      check32("proto_err", 32'(PROTO_ERR), 32'(perr_m));
      if (lac_seen) begin
        if (mdb_q.size() == 0) fail_now("mdb_out_queue");
        else check32("mdb_out", 32'(MDB_OUT), 32'(mdb_q.pop_front()));
      end
      if (MACFLAG && !prev_flag) begin
        if (acc_q.size() == 0) fail_now("acc_done_queue");
        else check32("acc_done", ACC, acc_q.pop_front());
      end
      prev_flag = MACFLAG;
    end
  end

  initial begin
    reset = 1'b1;
    LDA = 1'b0; LDB = 1'b0; LDC = 1'b0; CLEARACC = 1'b0; LAC = 1'b0; MDB_RAM = '0;
    repeat (2) @(posedge clk_12);
    #1;
    check32("init_macflag", 32'(MACFLAG), 32'd1);
    check32("init_acc", ACC, 32'd0);
    check32("init_mdb_out", 32'(MDB_OUT), 32'd0);
    check32("init_proto_err", 32'(PROTO_ERR), 32'd0);
    @(negedge clk_12);
    reset = 1'b0;

    // basic: (5-2)*4 = 12, then wrap with (0-1)*3
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    mac(16'h0005, 16'h0002, 16'h0004);
    idle(19);
    mac(16'h0000, 16'h0001, 16'h0003);
    idle(19);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(1);

    // operand extremes and wrap
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    mac(16'h8000, 16'h7FFF, 16'h8000);
    idle(19);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8000);
    idle(19);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(1);

    // preset ACC to 0x40000000, then LAC while a MAC is in flight
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      mac(16'h0000, 16'h4000, 16'h8000);
      idle(19);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    mac(16'h0001, 16'h0000, 16'h0100);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(14);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

    // loads while busy are dropped and flag a protocol error
    mac(16'h0002, 16'h0001, 16'h0007);
    idle(4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    idle(15);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    idle(3);

    // clear coinciding with completion, then async reset mid-multiply
    mac(16'h0003, 16'h0001, 16'h0009);
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
    idle(7);
    do_reset();
    mac(16'h0003, 16'h0001, 16'hFFFF);
    idle(19);

    // randomized traffic
    for (int i = 0; i < 25; i++) begin
      logic [15:0] a, b, c;
      a = 16'($urandom);
      b = 16'($urandom);
      c = 16'($urandom);
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      if ($urandom_range(0, 1) == 1) mac(a, b, c);
      else step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c);
      for (int k = 0; k < 19; k++)
        step($urandom_range(0, 19) == 0, 1'b0, 1'b0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 5) == 0, 16'($urandom));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    end

    idle(3);
    check32("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    check32("mdb_queue_drained", 32'(mdb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
